// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and default timing for the pipeline hazard controller.
// Imported by pipeline_hazard_ctrl and md_busy_timer.
package pipe_ctrl_pkg;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_EXC = 2'b01;
    localparam logic [1:0] PC_EPC = 2'b10;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
    localparam int CNT_W_DEF       = 4;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_md_busy_timer.sv
// Mult/div busy timer: RUN/MD_BUSY FSM with a down-counter.
// md_busy is high for exactly N cycles, starting the cycle after start.
module md_busy_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic md_busy
);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // State and counter registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: load on start, count down, leave when the count hits 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            RUN: begin
                if (start) begin
                    state_d = MD_BUSY;
                    cnt_d   = is_div ? CNT_W'(DIV_CYCLES)
                                     : CNT_W'(MULT_CYCLES);
                end
            end
            MD_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    assign md_busy = (state_q == MD_BUSY) & reset;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush scheduler for the five-stage pipeline registers and PC.
// Optional HAZARD_STATS_EN adds stall_cnt/flush_cnt event counters.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic        id_is_md,
    input  logic        ex_load,
    input  logic [4:0]  ex_dst,
    input  logic        ex_md_start,
    input  logic        ex_md_is_div,
    input  logic        mem_exc,
    input  logic        mem_eret,
    output logic        en_pc,
    output logic        en_fd,
    output logic        en_de,
    output logic        en_em,
    output logic        en_mw,
    output logic        clr_fd,
    output logic        clr_de,
    output logic        clr_em,
    output logic        clr_mw,
    output logic [1:0]  pc_sel,
`ifdef HAZARD_STATS_EN
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt,
`endif
    output logic        md_busy
);

    logic load_use;
    logic md_stall;
    logic stall;
    logic flush;
    logic md_start;

    assign flush    = mem_exc | mem_eret;
    assign md_start = ex_md_start & ~flush;

    md_busy_timer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_timer (
        .clk     (clk),
        .reset   (reset),
        .start   (md_start),
        .is_div  (ex_md_is_div),
        .md_busy (md_busy)
    );

    // Hazard detection: load-use on rs/rt and HI/LO access behind mult/div.
    always_comb begin
        load_use = ex_load & (ex_dst != 5'd0) &
                   ((id_use_rs & (id_rs == ex_dst)) |
                    (id_use_rt & (id_rt == ex_dst)));
        md_stall = id_is_md & (md_busy | ex_md_start);
        stall    = load_use | md_stall;
    end

    // Register controls; reset, then flush, then stall in priority order.
    always_comb begin
        en_pc  = 1'b1;
        en_fd  = 1'b1;
        en_de  = 1'b1;
        en_em  = 1'b1;
        en_mw  = 1'b1;
        clr_fd = 1'b0;
        clr_de = 1'b0;
        clr_em = 1'b0;
        clr_mw = 1'b0;
        pc_sel = PC_SEQ;
        if (!reset) begin
            clr_fd = 1'b1;
            clr_de = 1'b1;
            clr_em = 1'b1;
            clr_mw = 1'b1;
        end else if (flush) begin
            // The faulting instruction reaches W and is nullified there.
            clr_fd = 1'b1;
            clr_de = 1'b1;
            clr_em = 1'b1;
            pc_sel = mem_exc ? PC_EXC : PC_EPC;
        end else if (stall) begin
            en_pc  = 1'b0;
            en_fd  = 1'b0;
            clr_de = 1'b1;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Event counters; a stall hidden by a flush is not counted.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (flush) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end else if (stall) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Counter registers, cleared by reset and free to wrap.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl.
// Define HAZARD_STATS_EN to also check the event counters.
module tb_pipeline_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_use_rs;
    logic        id_use_rt;
    logic        id_is_md;
    logic        ex_load;
    logic [4:0]  ex_dst;
    logic        ex_md_start;
    logic        ex_md_is_div;
    logic        mem_exc;
    logic        mem_eret;
    logic        en_pc, en_fd, en_de, en_em, en_mw;
    logic        clr_fd, clr_de, clr_em, clr_mw;
    logic [1:0]  pc_sel;
    logic        md_busy;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    int checks;
    int errors;

    pipeline_hazard_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .id_is_md     (id_is_md),
        .ex_load      (ex_load),
        .ex_dst       (ex_dst),
        .ex_md_start  (ex_md_start),
        .ex_md_is_div (ex_md_is_div),
        .mem_exc      (mem_exc),
        .mem_eret     (mem_eret),
        .en_pc        (en_pc),
        .en_fd        (en_fd),
        .en_de        (en_de),
        .en_em        (en_em),
        .en_mw        (en_mw),
        .clr_fd       (clr_fd),
        .clr_de       (clr_de),
        .clr_em       (clr_em),
        .clr_mw       (clr_mw),
        .pc_sel       (pc_sel),
`ifdef HAZARD_STATS_EN
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt),
`endif
        .md_busy      (md_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected vectors: {en[4:0], clr[3:0], pc_sel, md_busy}
    localparam logic [11:0] V_RST   = {5'b11111, 4'b1111, 2'b00, 1'b0};
    localparam logic [11:0] V_IDLE  = {5'b11111, 4'b0000, 2'b00, 1'b0};
    localparam logic [11:0] V_STALL = {5'b00111, 4'b0100, 2'b00, 1'b0};
    localparam logic [11:0] V_EXC   = {5'b11111, 4'b1110, 2'b01, 1'b0};
    localparam logic [11:0] V_EPC   = {5'b11111, 4'b1110, 2'b10, 1'b0};
    localparam logic [11:0] BUSY    = 12'h001;

    function automatic logic [11:0] obs();
        return {en_pc, en_fd, en_de, en_em, en_mw,
                clr_fd, clr_de, clr_em, clr_mw, pc_sel, md_busy};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic idle_in();
        id_rs        = 5'd0;
        id_rt        = 5'd0;
        id_use_rs    = 1'b0;
        id_use_rt    = 1'b0;
        id_is_md     = 1'b0;
        ex_load      = 1'b0;
        ex_dst       = 5'd0;
        ex_md_start  = 1'b0;
        ex_md_is_div = 1'b0;
        mem_exc      = 1'b0;
        mem_eret     = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle_in();
        reset = 1'b0;
        next_cycle();
        next_cycle();
        settle();
        chk("reset", 32'(obs()), 32'(V_RST));

        reset = 1'b1;
        next_cycle();
        settle();
        chk("idle", 32'(obs()), 32'(V_IDLE));
        next_cycle();

        // Load-use on rs
        ex_load = 1'b1; ex_dst = 5'd8; id_rs = 5'd8; id_use_rs = 1'b1;
        settle();
        chk("lu_rs", 32'(obs()), 32'(V_STALL));
        next_cycle();
        // Destination r0 never stalls
        ex_dst = 5'd0; id_rs = 5'd0;
        settle();
        chk("lu_r0", 32'(obs()), 32'(V_IDLE));
        next_cycle();
        // Load-use on rt
        ex_dst = 5'd8; id_rs = 5'd3; id_rt = 5'd8;
        id_use_rs = 1'b0; id_use_rt = 1'b1;
        settle();
        chk("lu_rt", 32'(obs()), 32'(V_STALL));
        next_cycle();
        // Matching rs that is not read
        id_rs = 5'd8; id_rt = 5'd4;
        settle();
        chk("lu_nord", 32'(obs()), 32'(V_IDLE));
        next_cycle();
        idle_in();

        // Mult with HI/LO consumer held in D
        id_is_md = 1'b1; ex_md_start = 1'b1;
        settle();
        chk("mul_st", 32'(obs()), 32'(V_STALL));
        next_cycle();
        ex_md_start = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            settle();
            chk($sformatf("mul_b%0d", i), 32'(obs()),
                32'(V_STALL | BUSY));
            next_cycle();
        end
        settle();
        chk("mul_end", 32'(obs()), 32'(V_IDLE));
        next_cycle();
        idle_in();

        // Div with a non-md instruction in D
        ex_md_start = 1'b1; ex_md_is_div = 1'b1;
        settle();
        chk("div_st", 32'(obs()), 32'(V_IDLE));
        next_cycle();
        idle_in();
        for (int i = 1; i <= 10; i++) begin
            settle();
            chk($sformatf("div_b%0d", i), 32'(obs()),
                32'(V_IDLE | BUSY));
            next_cycle();
        end
        settle();
        chk("div_end", 32'(obs()), 32'(V_IDLE));
        next_cycle();

        // Flush overrides load-use
        ex_load = 1'b1; ex_dst = 5'd8; id_rs = 5'd8; id_use_rs = 1'b1;
        mem_exc = 1'b1;
        settle();
        chk("fl_exc", 32'(obs()), 32'(V_EXC));
        next_cycle();
        mem_eret = 1'b1;
        settle();
        chk("fl_both", 32'(obs()), 32'(V_EXC));
        next_cycle();
        idle_in();

        // Start squashed by eret
        ex_md_start = 1'b1; mem_eret = 1'b1;
        settle();
        chk("fl_eret", 32'(obs()), 32'(V_EPC));
        next_cycle();
        idle_in();
        settle();
        chk("sq_start", 32'(obs()), 32'(V_IDLE));
        next_cycle();

        // Flush during busy keeps the counter running
        ex_md_start = 1'b1;
        settle();
        next_cycle();
        idle_in();
        mem_exc = 1'b1;
        settle();
        chk("flb_1", 32'(obs()), 32'(V_EXC | BUSY));
        next_cycle();
        idle_in();
        for (int i = 2; i <= 5; i++) begin
            settle();
            chk($sformatf("flb_%0d", i), 32'(obs()), 32'(V_IDLE | BUSY));
            next_cycle();
        end
        settle();
        chk("flb_end", 32'(obs()), 32'(V_IDLE));
`ifdef HAZARD_STATS_EN
        chk("stall_cnt", stall_cnt, 32'd8);
        chk("flush_cnt", flush_cnt, 32'd4);
`endif
        next_cycle();

        // Reset at divide busy cycle 3
        ex_md_start = 1'b1; ex_md_is_div = 1'b1;
        settle();
        next_cycle();
        idle_in();
        next_cycle();
        next_cycle();
        settle();
        chk("rd_b3", 32'(md_busy), 32'd1);
        reset = 1'b0;
        next_cycle();
        settle();
        chk("rd_rst", 32'(obs()), 32'(V_RST));
        reset = 1'b1;
        next_cycle();
        settle();
        chk("rd_idle", 32'(obs()), 32'(V_IDLE));
`ifdef HAZARD_STATS_EN
        chk("rd_scnt", stall_cnt, 32'd0);
        chk("rd_fcnt", flush_cnt, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
